// File: rtl/move_ctrl_if.sv
// Player-input bundle: raw buttons and game enable in, move command stream and
// debounced button state out.
interface move_ctrl_if;
  logic       en;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       move_en;
  logic [1:0] direct;
  logic [3:0] held;

  modport master (
    output en, btn_up, btn_down, btn_left, btn_right,
    input  move_en, direct, held
  );

  modport slave (
    input  en, btn_up, btn_down, btn_left, btn_right,
    output move_en, direct, held
  );
endinterface

// File: rtl/move_ctrl.sv
// Player-input front end: synchronise and debounce four direction buttons, cancel
// opposing pairs, then issue rate-limited, round-robin move strobes.
module move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int STEP_DIV        = 4
) (
  input logic        clk_run,
  input logic        rst,
  move_ctrl_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ST_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STEP_DIV - 1);
  localparam logic [1:0] DIR_UP = 2'd0;

  logic [3:0]      raw;
  logic [3:0]      sync_p0;
  logic [3:0]      sync_p1;
  logic [3:0]      stable;
  logic [DB_W-1:0] db_cnt [4];
  logic [ST_W-1:0] step_cnt;
  logic [1:0]      last_idx;
  logic            move_en;
  logic [1:0]      direct;
  logic [3:0]      eff;
  logic [1:0]      sel;
  logic [1:0]      idx;

  // Bit order 0=UP 1=DOWN 2=LEFT 3=RIGHT, shared by held, eff and the direction code
  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  always_comb begin
    eff = bus.en ? stable : 4'b0000;
    if (eff[0] && eff[1]) eff[1:0] = 2'b00;
    if (eff[2] && eff[3]) eff[3:2] = 2'b00;
  end

  // Scan from the largest offset down so the nearest set bit after last_idx wins
  always_comb begin
    sel = last_idx;
    idx = last_idx;
    for (int k = 3; k >= 0; k--) begin
      idx = last_idx + 2'(k + 1);
      if (eff[idx]) sel = idx;
    end
  end

  always_ff @(posedge clk_run) begin
    if (rst) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable   <= '0;
      for (int b = 0; b < 4; b++) db_cnt[b] <= '0;
      step_cnt <= '0;
      move_en  <= 1'b0;
      direct   <= DIR_UP;
      last_idx <= 2'd3;
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      sync_p0 <= raw;
      sync_p1 <= sync_p0;

      // debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples
      for (int b = 0; b < 4; b++) begin
        if (sync_p1[b] == stable[b]) begin
          db_cnt[b] <= '0;
        end else if (db_cnt[b] == DB_LAST) begin
          stable[b] <= sync_p1[b];
          db_cnt[b] <= '0;
        end else begin
          db_cnt[b] <= db_cnt[b] + 1'b1;
        end
      end

      if (eff == 4'b0000)
        step_cnt <= '0;
      else
        step_cnt <= (step_cnt == ST_LAST) ? '0 : step_cnt + 1'b1;

      // issue: direction code equals the bit index of the selected key
      if ((eff != 4'b0000) && (step_cnt == '0)) begin
        move_en  <= 1'b1;
        direct   <= sel;
        last_idx <= sel;
      end else begin
        move_en  <= 1'b0;
      end
    end
  end

  assign bus.move_en = move_en;
  assign bus.direct  = direct;
  assign bus.held    = stable;

endmodule

// File: tb/tb_move_ctrl.sv
// Randomised and directed bench for move_ctrl against a behavioural model of the
// button/debounce/step/round-robin rules.
module tb_move_ctrl;
  localparam int D = 4;
  localparam int S = 3;
  localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  move_ctrl_if bus();

  move_ctrl #(.DEBOUNCE_CYCLES(D), .STEP_DIV(S)) dut (
    .clk_run (clk),
    .rst     (rst),
    .bus     (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // model state
  logic [3:0] m_dly [$];
  logic [3:0] m_stable;
  int         m_run [4];
  int         m_since;
  logic       m_move;
  logic [1:0] m_dir;
  logic [1:0] m_last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_left  = m[2];
    bus.btn_right = m[3];
  endtask

  function automatic logic [3:0] raw_now();
    return {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};
  endfunction

  // One clock edge of the reference: inputs are those present at the edge.
  task automatic model_edge();
    logic [3:0] eff;
    logic [3:0] sync;
    int         pick;
    if (rst) begin
      m_dly    = '{4'b0, 4'b0};
      m_stable = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      m_since  = 0;
      m_move   = 1'b0;
      m_dir    = UP;
      m_last   = 2'd3;
    end else begin
      eff = bus.en ? m_stable : 4'b0;
      if (eff[0] && eff[1]) eff[1:0] = 2'b00;
      if (eff[2] && eff[3]) eff[3:2] = 2'b00;
      if (eff != 0 && (m_since % S) == 0) begin
        pick = -1;
        for (int off = 1; off <= 4; off++)
          if (pick < 0 && eff[(m_last + off) % 4]) pick = (m_last + off) % 4;
        m_move = 1'b1;
        m_dir  = 2'(pick);
        m_last = 2'(pick);
      end else begin
        m_move = 1'b0;
      end
      m_since = (eff == 0) ? 0 : m_since + 1;
      // buttons reach the debouncer two edges after they are sampled
      sync = m_dly[0];
      void'(m_dly.pop_front());
      m_dly.push_back(raw_now());
      for (int b = 0; b < 4; b++) begin
        if (sync[b] != m_stable[b]) begin
          if (m_run[b] + 1 == D) begin
            m_stable[b] = sync[b];
            m_run[b]    = 0;
          end else begin
            m_run[b]++;
          end
        end else begin
          m_run[b] = 0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("move_en", 32'(bus.move_en), 32'(m_move));
    check_eq("direct",  32'(bus.direct),  32'(m_dir));
    check_eq("held",    32'(bus.held),    32'(m_stable));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int         npulse;
    logic [1:0] prev_dir;
    logic       seen;
    logic [3:0] mask;
    int         len;

    m_dly = '{4'b0, 4'b0};
    rst   = 1'b1;
    bus.en = 1'b1;
    set_btn(4'b0000);
    #2;
    steps(2);
    rst = 1'b0;
    check_eq("rst_move",   32'(bus.move_en), 0);
    check_eq("rst_direct", 32'(bus.direct),  32'(UP));
    check_eq("rst_held",   32'(bus.held),    0);

    // up held: accepted after edge 6, pulses after edges 7, 10, 13
    set_btn(4'b0001);
    for (int e = 1; e <= 13; e++) begin
      step();
      check_eq($sformatf("up_pulse_e%0d", e), 32'(bus.move_en),
               32'((e == 7) || (e == 10) || (e == 13)));
      check_eq($sformatf("up_held_e%0d", e), 32'(bus.held[0]), 32'(e >= 6));
    end
    check_eq("up_dir", 32'(bus.direct), 32'(UP));
    set_btn(4'b0000);
    steps(12);

    // 3-cycle glitch is rejected, 4-cycle pulse is accepted
    set_btn(4'b0100);
    steps(3);
    set_btn(4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.held != 0 || bus.move_en) seen = 1'b1;
    end
    check_eq("glitch_ignored", 32'(seen), 0);
    set_btn(4'b0100);
    steps(4);
    set_btn(4'b0000);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.held[2]) seen = 1'b1;
    end
    check_eq("pulse4_accepted", 32'(seen), 1);
    steps(8);

    // reset in mid-debounce discards progress
    set_btn(4'b0001);
    steps(3);
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    check_eq("midrst_move",   32'(bus.move_en), 0);
    check_eq("midrst_direct", 32'(bus.direct),  32'(UP));
    check_eq("midrst_held",   32'(bus.held),    0);
    steps(5);
    check_eq("midrst_held_e5", 32'(bus.held[0]), 0);
    step();
    check_eq("midrst_held_e6", 32'(bus.held[0]), 1);
    set_btn(4'b0000);
    steps(12);

    // up + right alternate
    set_btn(4'b1001);
    npulse = 0;
    prev_dir = UP;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.move_en) begin
        if (npulse > 0) check_eq("alternate", 32'(bus.direct != prev_dir), 1);
        prev_dir = bus.direct;
        npulse++;
      end
    end
    check_eq("alt_pulses", 32'(npulse >= 4), 1);
    set_btn(4'b0000);
    steps(12);

    // up + down cancel; adding left gives only LEFT
    set_btn(4'b0011);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (bus.move_en) seen = 1'b1;
    end
    check_eq("updown_held", 32'(bus.held), 32'(4'b0011));
    check_eq("updown_nomove", 32'(seen), 0);
    set_btn(4'b0111);
    npulse = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (bus.move_en) begin
        check_eq("left_only", 32'(bus.direct), 32'(LEFT));
        npulse++;
      end
    end
    check_eq("left_pulses", 32'(npulse > 0), 1);
    set_btn(4'b0000);
    steps(12);

    // en low blocks moves; raising it pulses at the next edge
    bus.en = 1'b0;
    set_btn(4'b1000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.move_en) seen = 1'b1;
    end
    check_eq("en0_nomove", 32'(seen), 0);
    check_eq("en0_held", 32'(bus.held), 32'(4'b1000));
    bus.en = 1'b1;
    step();
    check_eq("en1_first_pulse", 32'(bus.move_en), 1);
    check_eq("en1_dir", 32'(bus.direct), 32'(RIGHT));
    set_btn(4'b0000);
    steps(12);

    // randomised phases
    for (int p = 0; p < 250; p++) begin
      mask   = 4'($urandom_range(0, 15));
      len    = $urandom_range(1, 14);
      bus.en = ($urandom_range(0, 7) != 0);
      rst    = ($urandom_range(0, 39) == 0);
      set_btn(mask);
      step();
      rst = 1'b0;
      steps(len - 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
